// File: rtl/alu_pkg.sv
// Shared definitions for the iterative execute-stage ALU: operation codes and FSM states.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_XOR  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_ADD  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_MUL  = 4'b0101;
  localparam logic [3:0] ALU_ADDI = 4'b0110;
  localparam logic [3:0] ALU_SRAI = 4'b0111;
  localparam logic [3:0] ALU_LDST = 4'b1000;
  localparam logic [3:0] ALU_BEQ  = 4'b1001;

  typedef enum logic {
    IDLE,
    MUL
  } alu_state_t;

endpackage

// File: rtl/alu_iter_mul.sv
// Iterative shift-add multiplier consuming MUL_BITS multiplier bits per cycle.
// Define ALU_MUL_EARLY_TERM_EN to finish as soon as the remaining multiplier is zero.
module mul_iter #(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0] mplier_i,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  localparam int N  = WIDTH / MUL_BITS;
  localparam int CW = $clog2(N + 1);

  logic [WIDTH-1:0] mcand, mplier, acc;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] digit, acc_step, mplier_step;
  logic             busy, last;

  assign busy        = (cnt != '0);
  assign digit       = WIDTH'(mplier[MUL_BITS-1:0]);
  assign acc_step    = acc + mcand * digit;
  assign mplier_step = mplier >> MUL_BITS;

`ifdef ALU_MUL_EARLY_TERM_EN
  // Once the shifted-out multiplier is empty, the remaining steps would add nothing.
  assign last = busy && (mplier_step == '0);
`else
  assign last = (cnt == CW'(1));
`endif

  // The product of the completing step is presented combinationally so the
  // top can register it on the same edge.
  assign done_o    = last & ~abort_i;
  assign product_o = acc_step;

  // NOTE: datapath registers are reset along with the counter so a reset
  // mid-operation leaves no stale partial product visible anywhere.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (abort_i) begin
      cnt <= '0;
    end else if (start_i) begin
      mcand  <= mcand_i;
      mplier <= mplier_i;
      acc    <= '0;
      cnt    <= CW'(N);
    end else if (busy) begin
      // NOTE: non-blocking updates so every register steps from the same old values.
      acc    <= acc_step;
      mcand  <= mcand << MUL_BITS;
      mplier <= mplier_step;
      cnt    <= last ? '0 : cnt - CW'(1);
    end
  end

endmodule

// File: rtl/alu_iter.sv
// Execute-stage ALU: single-cycle ops plus an iterative multiply, registered outputs,
// valid/ready handshake. ALU_MUL_EARLY_TERM_EN enables early multiply completion.
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             flush_i,
  input  logic [3:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             valid_o
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_t       state, state_n;
  logic [WIDTH-1:0] single_res, mul_product, result_n;
  logic [SHW-1:0]   shamt;
  logic             zero_n, valid_n;
  logic             accept, mul_start, mul_abort, mul_done;

  assign ready_o   = (state == IDLE);
  assign accept    = valid_i & ready_o & ~flush_i;
  assign mul_start = accept && (ALUCtrl_i == ALU_MUL);
  assign mul_abort = flush_i && (state == MUL);
  assign shamt     = data2_i[SHW-1:0];

  mul_iter #(
    .WIDTH    (WIDTH),
    .MUL_BITS (MUL_BITS)
  ) u_mul (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (mul_start),
    .abort_i   (mul_abort),
    .mcand_i   (data1_i),
    .mplier_i  (data2_i),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  // NOTE: a default before the case keeps this purely combinational (no latch).
  always_comb begin
    single_res = '0;
    case (ALUCtrl_i)
      ALU_AND:                     single_res = data1_i & data2_i;
      ALU_XOR:                     single_res = data1_i ^ data2_i;
      ALU_SLL:                     single_res = data1_i << shamt;
      ALU_ADD, ALU_ADDI, ALU_LDST: single_res = data1_i + data2_i;
      ALU_SUB, ALU_BEQ:            single_res = data1_i - data2_i;
      ALU_SRAI:                    single_res = WIDTH'($signed(data1_i) >>> shamt);
      default:                     single_res = '0;
    endcase
  end

  always_comb begin
    state_n  = state;
    result_n = result_o;
    zero_n   = zero_o;
    valid_n  = 1'b0;
    case (state)
      IDLE: begin
        if (mul_start) begin
          state_n = MUL;
        end else if (accept) begin
          result_n = single_res;
          zero_n   = (single_res == '0);
          valid_n  = 1'b1;
        end
      end
      MUL: begin
        if (flush_i) begin
          state_n = IDLE;
        end else if (mul_done) begin
          result_n = mul_product;
          zero_n   = (mul_product == '0);
          valid_n  = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      result_o <= '0;
      zero_o   <= 1'b1;
      valid_o  <= 1'b0;
    end else begin
      result_o <= result_n;
      zero_o   <= zero_n;
      valid_o  <= valid_n;
    end
  end

endmodule
